switch_crossbar_scheduler: RTL and testbench

- Packet-granular connection scheduler for the RADIX-port switch crossbar.
- Takes per-input head-of-line requests as unicast or multicast destination bitmasks and allocates outputs all-or-nothing, using round-robin fairness across inputs.
- Holds each connection until the input's tlast beat handshakes, then releases it.
- Drives the crossbar's per-input valid gating and per-output connection matrix. An optional watchdog breaks stalled connections.

---
 rtl/switch_crossbar_scheduler.sv | 145 ++++++++++++++
 tb/tb_switch_crossbar_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_crossbar_scheduler.sv
// Packet-granular crossbar connection scheduler: all-or-nothing output allocation
// with round-robin priority, release on tlast, and an optional stall watchdog.
module switch_crossbar_scheduler #(
  parameter int unsigned RADIX         = 4,
  parameter int unsigned TIMEOUT       = 0,
  parameter int unsigned TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [RADIX-1:0]         req_valid,
  input  logic [RADIX*RADIX-1:0]   req_dest,
  input  logic [RADIX-1:0]         s_axis_tvalid,
  input  logic [RADIX-1:0]         s_axis_tready,
  input  logic [RADIX-1:0]         s_axis_tlast,
  input  logic [RADIX-1:0]         out_enable,
  output logic [RADIX-1:0]         grant,
  output logic [RADIX*RADIX-1:0]   conn,
  output logic [RADIX-1:0]         out_busy,
  output logic [RADIX-1:0]         zero_dest_err,
  output logic [RADIX-1:0]         timeout_pulse
);

  localparam int unsigned PTR_W = (RADIX > 1) ? $clog2(RADIX) : 1;
  localparam int unsigned CNT_W = TIMEOUT_WIDTH;
  localparam int          R     = RADIX;

  logic [RADIX-1:0]       grant_q, grant_d;
  logic [RADIX-1:0]       dmask_q [RADIX];
  logic [RADIX-1:0]       dmask_d [RADIX];
  logic [CNT_W-1:0]       idle_q  [RADIX];
  logic [CNT_W-1:0]       idle_d  [RADIX];
  logic [PTR_W-1:0]       rr_q, rr_d;
  logic [RADIX-1:0]       out_busy_q, out_busy_d;
  logic [RADIX*RADIX-1:0] conn_q, conn_d;
  logic [RADIX-1:0]       zerr_q, zerr_d;
  logic [RADIX-1:0]       tpulse_q, tpulse_d;

  logic [RADIX-1:0]       dest_a [RADIX];
  logic [RADIX-1:0]       new_grant;
  logic [RADIX-1:0]       claimed;
  logic [RADIX-1:0]       release_c;
  logic                   found;
  int                     sel;

  // Next-state: round-robin allocation, release, watchdog and derived outputs
  always_comb begin
    new_grant  = '0;
    claimed    = '0;
    found      = 1'b0;
    sel        = 0;
    rr_d       = rr_q;
    grant_d    = grant_q;
    tpulse_d   = '0;
    zerr_d     = '0;
    out_busy_d = '0;
    conn_d     = '0;
    release_c  = s_axis_tvalid & s_axis_tready & s_axis_tlast & grant_q;

    for (int i = 0; i < R; i++) begin
      dest_a[i]  = req_dest[i*R +: R];
      dmask_d[i] = dmask_q[i];
      idle_d[i]  = idle_q[i];
    end

    // Scan starting at rr_q; claimed keeps same-cycle winners disjoint
    for (int k = 0; k < R; k++) begin
      sel = int'(rr_q) + k;
      if (sel >= R) sel = sel - R;
      for (int i = 0; i < R; i++) begin
        if (i == sel && req_valid[i] && !grant_q[i] && (dest_a[i] != '0) &&
            ((dest_a[i] & (out_busy_q | claimed | ~out_enable)) == '0)) begin
          new_grant[i] = 1'b1;
          claimed      = claimed | dest_a[i];
          if (!found) begin
            rr_d  = PTR_W'((i + 1) % R);
            found = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < R; i++) begin
      zerr_d[i] = req_valid[i] & ~grant_q[i] & (dest_a[i] == '0);
      if (grant_q[i]) begin
        // A tlast release takes precedence over a coincident timeout
        if (release_c[i]) begin
          grant_d[i] = 1'b0;
          idle_d[i]  = '0;
        end else if (TIMEOUT != 0 && idle_q[i] == CNT_W'(TIMEOUT)) begin
          grant_d[i]  = 1'b0;
          tpulse_d[i] = 1'b1;
          idle_d[i]   = '0;
        end else if (TIMEOUT == 0 || s_axis_tvalid[i]) begin
          idle_d[i] = '0;
        end else begin
          idle_d[i] = idle_q[i] + CNT_W'(1);
        end
      end else begin
        grant_d[i] = new_grant[i];
        idle_d[i]  = '0;
        if (new_grant[i]) dmask_d[i] = dest_a[i];
      end
    end

    for (int i = 0; i < R; i++) begin
      if (grant_d[i]) out_busy_d = out_busy_d | dmask_d[i];
      for (int m = 0; m < R; m++) begin
        conn_d[m*R + i] = grant_d[i] & dmask_d[i][m];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_q    <= '0;
      rr_q       <= '0;
      out_busy_q <= '0;
      conn_q     <= '0;
      zerr_q     <= '0;
      tpulse_q   <= '0;
      for (int i = 0; i < R; i++) begin
        dmask_q[i] <= '0;
        idle_q[i]  <= '0;
      end
    end else begin
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      out_busy_q <= out_busy_d;
      conn_q     <= conn_d;
      zerr_q     <= zerr_d;
      tpulse_q   <= tpulse_d;
      for (int i = 0; i < R; i++) begin
        dmask_q[i] <= dmask_d[i];
        idle_q[i]  <= idle_d[i];
      end
    end
  end

  assign grant         = grant_q;
  assign conn          = conn_q;
  assign out_busy      = out_busy_q;
  assign zero_dest_err = zerr_q;
  assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_switch_crossbar_scheduler.sv
// Scoreboard bench for switch_crossbar_scheduler (RADIX=4, TIMEOUT=8).
module tb_switch_crossbar_scheduler;

  localparam int R = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [R-1:0]   req_valid;
  logic [R*R-1:0] req_dest;
  logic [R-1:0]   s_axis_tvalid, s_axis_tready, s_axis_tlast, out_enable;
  logic [R-1:0]   grant, out_busy, zero_dest_err, timeout_pulse;
  logic [R*R-1:0] conn;

  switch_crossbar_scheduler #(
    .RADIX(R), .TIMEOUT(8), .TIMEOUT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dest(req_dest),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .out_enable(out_enable),
    .grant(grant), .conn(conn), .out_busy(out_busy),
    .zero_dest_err(zero_dest_err), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    string       nm;
    logic [3:0]  g;
    logic [3:0]  b;
    logic [15:0] cn;
    logic [3:0]  ze;
    logic [3:0]  tp;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input int c, input string nm, input logic [3:0] g,
                      input logic [3:0] b, input logic [15:0] cn,
                      input logic [3:0] ze, input logic [3:0] tp);
    exp_t x;
    x.c = c; x.nm = nm; x.g = g; x.b = b; x.cn = cn; x.ze = ze; x.tp = tp;
    sb.push_back(x);
  endtask

  task automatic cmp(input string nm, input string fld,
                     input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s at cycle %0d: got %h expected %h", nm, fld, cyc, act, expv);
    end
  endtask

  // Monitor: compare every expectation due at the current cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      if (e.c < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.nm, e.c, cyc);
      end else begin
        cmp(e.nm, "grant",   16'(grant),         16'(e.g));
        cmp(e.nm, "busy",    16'(out_busy),      16'(e.b));
        cmp(e.nm, "conn",    conn,               e.cn);
        cmp(e.nm, "zerr",    16'(zero_dest_err), 16'(e.ze));
        cmp(e.nm, "tpulse",  16'(timeout_pulse), 16'(e.tp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int i, input logic [3:0] v);
    req_dest[i*4 +: 4] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    rst = 1'b0; req_valid = '0; req_dest = '0;
    s_axis_tvalid = 4'hF; s_axis_tready = '0; s_axis_tlast = '0; out_enable = 4'hF;

    // Reset
    repeat (3) step();
    t = cyc; push(t+1, "reset", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step(); rst = 1'b1;

    // Basic unicast
    step(); t = cyc;
    req_valid = 4'b0001; set_dest(0, 4'b0100);
    push(t+1, "uni_grant", 4'b0001, 4'b0100, 16'h0100, 4'b0, 4'b0);
    step(); req_valid = '0;
    step(); step();
    push(t+3, "uni_hold", 4'b0001, 4'b0100, 16'h0100, 4'b0, 4'b0);
    step();
    s_axis_tready = 4'b0001; s_axis_tlast = 4'b0001;
    push(t+4, "uni_last", 4'b0001, 4'b0100, 16'h0100, 4'b0, 4'b0);
    push(t+5, "uni_rel",  4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    step(); s_axis_tready = '0; s_axis_tlast = '0;

    // Contention on output 0, round robin from pointer 1
    step(); t = cyc;
    req_valid = 4'b0111;
    set_dest(0, 4'b0001); set_dest(1, 4'b0001); set_dest(2, 4'b0001);
    s_axis_tready = 4'b0111; s_axis_tlast = 4'b0111;
    push(t+1, "rr_in1",  4'b0010, 4'b0001, 16'h0002, 4'b0, 4'b0);
    push(t+2, "rr_gap1", 4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    push(t+3, "rr_in2",  4'b0100, 4'b0001, 16'h0004, 4'b0, 4'b0);
    push(t+4, "rr_gap2", 4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    push(t+5, "rr_in0",  4'b0001, 4'b0001, 16'h0001, 4'b0, 4'b0);
    push(t+6, "rr_gap3", 4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    push(t+7, "rr_in1b", 4'b0010, 4'b0001, 16'h0002, 4'b0, 4'b0);
    push(t+8, "rr_end",  4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    repeat (7) step();
    req_valid = '0;
    step(); s_axis_tready = '0; s_axis_tlast = '0;

    // Multicast all-or-nothing with a parallel unicast
    step(); t = cyc;
    req_valid = 4'b0010; set_dest(1, 4'b0100);
    push(t+1, "mc_hold1", 4'b0010, 4'b0100, 16'h0200, 4'b0, 4'b0);
    step();
    req_valid = 4'b1001; set_dest(0, 4'b0001); set_dest(3, 4'b0110);
    push(t+2, "mc_par",  4'b0011, 4'b0101, 16'h0201, 4'b0, 4'b0);
    push(t+3, "mc_wait", 4'b0011, 4'b0101, 16'h0201, 4'b0, 4'b0);
    step(); step();
    s_axis_tready = 4'b0010; s_axis_tlast = 4'b0010;
    push(t+4, "mc_rel1",  4'b0001, 4'b0001, 16'h0001, 4'b0, 4'b0);
    step(); s_axis_tready = '0; s_axis_tlast = '0;
    push(t+5, "mc_grant", 4'b1001, 4'b0111, 16'h0881, 4'b0, 4'b0);
    step(); req_valid = '0;
    step();
    s_axis_tready = 4'b1001; s_axis_tlast = 4'b1001;
    push(t+7, "mc_rel", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step(); s_axis_tready = '0; s_axis_tlast = '0;

    // Output pause
    step(); t = cyc;
    out_enable = 4'b1110; req_valid = 4'b0100; set_dest(2, 4'b0001);
    push(t+1, "pause1", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    push(t+2, "pause2", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step(); step();
    out_enable = 4'hF;
    push(t+3, "unpause", 4'b0100, 4'b0001, 16'h0004, 4'b0, 4'b0);
    step();
    req_valid = '0; s_axis_tready = 4'b0100; s_axis_tlast = 4'b0100;
    push(t+4, "unpause_rel", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step(); s_axis_tready = '0; s_axis_tlast = '0;

    // Zero destination
    step(); t = cyc;
    req_valid = 4'b0010; set_dest(1, 4'b0000);
    push(t+1, "zd1", 4'b0, 4'b0, 16'h0, 4'b0010, 4'b0);
    push(t+2, "zd2", 4'b0, 4'b0, 16'h0, 4'b0010, 4'b0);
    step(); step();
    req_valid = '0;
    push(t+3, "zd_off", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step();

    // Watchdog: 7-cycle gaps survive, a long stall fires after 9 cycles
    step(); t = cyc;
    req_valid = 4'b0001; set_dest(0, 4'b1000);
    push(t+1, "wd_grant", 4'b0001, 4'b1000, 16'h1000, 4'b0, 4'b0);
    step(); req_valid = '0;
    for (int r = 0; r < 2; r++) begin
      t = cyc;
      s_axis_tvalid[0] = 1'b0;
      repeat (7) step();
      s_axis_tvalid[0] = 1'b1;
      push(t+7, "wd_tog_lo", 4'b0001, 4'b1000, 16'h1000, 4'b0, 4'b0);
      push(t+8, "wd_tog_hi", 4'b0001, 4'b1000, 16'h1000, 4'b0, 4'b0);
      repeat (7) step();
    end
    t = cyc;
    s_axis_tvalid[0] = 1'b0;
    push(t+8,  "wd_pre",   4'b0001, 4'b1000, 16'h1000, 4'b0, 4'b0);
    push(t+9,  "wd_fire",  4'b0,    4'b0,    16'h0,    4'b0, 4'b0001);
    push(t+10, "wd_after", 4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    repeat (10) step();
    s_axis_tvalid = 4'hF;

    // Release coinciding with watchdog expiry counts as a plain release
    step(); t = cyc;
    req_valid = 4'b0001; set_dest(0, 4'b0001);
    push(t+1, "sim_grant", 4'b0001, 4'b0001, 16'h0001, 4'b0, 4'b0);
    step(); req_valid = '0; s_axis_tvalid[0] = 1'b0;
    repeat (8) step();
    s_axis_tvalid[0] = 1'b1; s_axis_tready[0] = 1'b1; s_axis_tlast[0] = 1'b1;
    push(t+9,  "sim_pre", 4'b0001, 4'b0001, 16'h0001, 4'b0, 4'b0);
    push(t+10, "sim_rel", 4'b0,    4'b0,    16'h0,    4'b0, 4'b0);
    step(); s_axis_tready = '0; s_axis_tlast = '0;

    // Reset mid-packet, then pointer restarts at 0
    step(); t = cyc;
    req_valid = 4'b0100; set_dest(2, 4'b0010);
    push(t+1, "rst_pre", 4'b0100, 4'b0010, 16'h0040, 4'b0, 4'b0);
    step(); req_valid = '0; rst = 1'b0;
    push(t+2, "rst_mid", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step(); rst = 1'b1;
    req_valid = 4'b1010; set_dest(1, 4'b0001); set_dest(3, 4'b0001);
    push(t+3, "rst_rr", 4'b0010, 4'b0001, 16'h0002, 4'b0, 4'b0);
    step();
    req_valid = '0; s_axis_tready = 4'b0010; s_axis_tlast = 4'b0010;
    push(t+4, "rst_rel", 4'b0, 4'b0, 16'h0, 4'b0, 4'b0);
    step(); s_axis_tready = '0; s_axis_tlast = '0;
    repeat (3) step();

    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: expectation for cycle %0d left unchecked", e.nm, e.c);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
